// File: rtl/cdb_arbiter.sv
// cdb_arbiter: completion arbiter between functional units and the common data bus.
// Each source owns a small circular FIFO of {tag,value} results. One
// non-empty FIFO is granted per cycle, round-robin from rr_ptr. The
// winner's head is driven as a registered broadcast.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   flush              squash: drops all buffered and outgoing results
//   src_valid/ready    per-source valid/ready handshake
//   src_tag/src_value  per-source result, packed as source i at [i*W +: W]
//   cdb_valid/tag/value registered broadcast
//   cdb_src            index of the granted source

`ifndef ROB_TAG_BITS
`define ROB_TAG_BITS 6
`endif

module cdb_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int TAG_BITS  = `ROB_TAG_BITS,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2,
  localparam int SW       = $clog2(NUM_SRC)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*TAG_BITS-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]    src_value,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         cdb_valid,
  output logic [TAG_BITS-1:0]          cdb_tag,
  output logic [DATA_W-1:0]            cdb_value,
  output logic [SW-1:0]                cdb_src
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = TAG_BITS + DATA_W;

  logic [EW-1:0]       mem_q   [NUM_SRC][BUF_DEPTH];
  logic [CW-1:0]       count_q [NUM_SRC];
  logic [CW-1:0]       count_d [NUM_SRC];
  logic [PW-1:0]       head_q  [NUM_SRC];
  logic [PW-1:0]       head_d  [NUM_SRC];
  logic [PW-1:0]       tail_q  [NUM_SRC];
  logic [PW-1:0]       tail_d  [NUM_SRC];
  logic [SW-1:0]       rr_q, rr_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [TAG_BITS-1:0] cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]   cdb_value_q, cdb_value_d;
  logic [SW-1:0]       cdb_src_q, cdb_src_d;

  logic [NUM_SRC-1:0]  push, pop;
  logic                grant;
  logic [SW-1:0]       win;
  logic [SW-1:0]       idx;
  logic [EW-1:0]       head_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on the registered count, so a full FIFO refuses
  // a push even in a cycle where it is also being popped.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !reset && (count_q[i] < CW'(BUF_DEPTH));
      push[i]      = src_valid[i] && src_ready[i] && !flush;
    end
  end

  // Round-robin pick: first non-empty FIFO at or after rr_q. NUM_SRC is a
  // power of two, so the SW-bit sum wraps naturally.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      idx = rr_q + SW'(off);
      if (!grant && count_q[idx] != '0) begin
        grant = 1'b1;
        win   = idx;
      end
    end
  end

  assign head_entry = mem_q[win][head_q[win]];

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant && !flush && (win == SW'(i));
    end
  end

  always_comb begin
    rr_d        = rr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      count_d[i] = count_q[i];
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
    end
    if (flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        count_d[i] = '0;
        head_d[i]  = '0;
        tail_d[i]  = '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) tail_d[i] = ptr_inc(tail_q[i]);
        if (pop[i])  head_d[i] = ptr_inc(head_q[i]);
        count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (grant) begin
        rr_d        = win + SW'(1);
        cdb_valid_d = 1'b1;
        cdb_tag_d   = head_entry[EW-1:DATA_W];
        cdb_value_d = head_entry[DATA_W-1:0];
        cdb_src_d   = win;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        count_q[i] <= '0;
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
      end
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        count_q[i] <= count_d[i];
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
      end
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  // Storage needs no reset; push is already gated by reset and flush.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem_q[i][tail_q[i]] <= {src_tag[i*TAG_BITS +: TAG_BITS],
                                src_value[i*DATA_W +: DATA_W]};
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter (4 sources, 6-bit tags,
// 32-bit values, 2-entry FIFOs). Inputs are driven and outputs sampled
// 1 time unit after each rising edge.

module tb_cdb_arbiter;

  localparam int NS = 4;
  localparam int TB = 6;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic [NS-1:0]     src_valid;
  logic [NS*TB-1:0]  src_tag;
  logic [NS*DW-1:0]  src_value;
  logic [NS-1:0]     src_ready;
  logic              cdb_valid;
  logic [TB-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_value;
  logic [1:0]        cdb_src;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(
    .NUM_SRC  (NS),
    .TAG_BITS (TB),
    .DATA_W   (DW),
    .BUF_DEPTH(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .src_valid(src_valid),
    .src_tag  (src_tag),
    .src_value(src_value),
    .src_ready(src_ready),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_value(cdb_value),
    .cdb_src  (cdb_src)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int i, input logic [TB-1:0] tag, input logic [DW-1:0] val);
    src_valid[i]         = 1'b1;
    src_tag[i*TB +: TB]  = tag;
    src_value[i*DW +: DW] = val;
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_tag   = '0;
    src_value = '0;
  endtask

  task automatic expect_bc(input string name, input logic [TB-1:0] tag,
                           input logic [DW-1:0] val, input logic [1:0] src);
    check_eq({name, "_valid"}, 64'(cdb_valid), 64'd1);
    check_eq({name, "_tag"},   64'(cdb_tag),   64'(tag));
    check_eq({name, "_value"}, 64'(cdb_value), 64'(val));
    check_eq({name, "_src"},   64'(cdb_src),   64'(src));
  endtask

  int          acc [NS];
  int          bc  [NS];
  logic [1:0]  s;
  logic [3:0]  seq;
  logic [TB-1:0] exp_tag;
  logic        seen_low;

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_src();
    step();
    step();

    // Reset state
    check_eq("rst_ready", 64'(src_ready), 64'h0);
    check_eq("rst_valid", 64'(cdb_valid), 64'h0);
    check_eq("rst_tag",   64'(cdb_tag),   64'h0);
    check_eq("rst_value", 64'(cdb_value), 64'h0);
    check_eq("rst_src",   64'(cdb_src),   64'h0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", 64'(src_ready), 64'hF);
    step();

    // Contention, rr_ptr=0: order 0,1,2,3, rr wraps to 0
    for (int i = 0; i < NS; i++) set_src(i, TB'(i + 1), 32'hC000_0000 + DW'(i));
    step();
    clear_src();
    check_eq("cont_lat", 64'(cdb_valid), 64'h0);
    step();
    for (int k = 0; k < NS; k++) begin
      expect_bc("cont", TB'(k + 1), 32'hC000_0000 + DW'(k), 2'(k));
      step();
    end
    check_eq("cont_idle", 64'(cdb_valid), 64'h0);

    // Single result from source 2 (rr becomes 3)
    set_src(2, 6'd5, 32'h1234_5678);
    step();
    clear_src();
    check_eq("single_lat", 64'(cdb_valid), 64'h0);
    step();
    expect_bc("single", 6'd5, 32'h1234_5678, 2'd2);
    step();
    check_eq("single_idle", 64'(cdb_valid), 64'h0);

    // Fairness/wrap: rr=3, sources 1 and 3 -> 3 then 1, rr becomes 2
    set_src(1, 6'd9,  32'hF1);
    set_src(3, 6'd10, 32'hF3);
    step();
    clear_src();
    step();
    expect_bc("fair_a", 6'd10, 32'hF3, 2'd3);
    step();
    expect_bc("fair_b", 6'd9, 32'hF1, 2'd1);
    step();
    check_eq("fair_idle", 64'(cdb_valid), 64'h0);

    // rr=2 is visible as grant order 2,3,0,1
    for (int i = 0; i < NS; i++) set_src(i, TB'(20 + i), 32'hD000_0000 + DW'(i));
    step();
    clear_src();
    step();
    for (int k = 0; k < NS; k++) begin
      expect_bc("rr2", TB'(20 + ((k + 2) % NS)), 32'hD000_0000 + DW'((k + 2) % NS), 2'((k + 2) % NS));
      step();
    end

    // Flush: source 0 granted first (rr 2 -> 1), then flush drops the rest
    set_src(0, 6'd30, 32'hE0);
    set_src(1, 6'd31, 32'hE1);
    step();
    set_src(0, 6'd32, 32'hE2);
    set_src(1, 6'd33, 32'hE3);
    step();
    expect_bc("pre_flush", 6'd30, 32'hE0, 2'd0);
    clear_src();
    flush = 1'b1;
    set_src(2, 6'd34, 32'hE4);
    step();
    flush = 1'b0;
    clear_src();
    check_eq("flush_valid", 64'(cdb_valid), 64'h0);
    check_eq("flush_ready", 64'(src_ready), 64'hF);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("flush_quiet", 64'(cdb_valid), 64'h0);
    end
    // rr preserved at 1 across the flush: order 1,2,3,0
    for (int i = 0; i < NS; i++) set_src(i, TB'(40 + i), 32'hA000_0000 + DW'(i));
    step();
    clear_src();
    step();
    for (int k = 0; k < NS; k++) begin
      expect_bc("rr_kept", TB'(40 + ((k + 1) % NS)), 32'hA000_0000 + DW'((k + 1) % NS), 2'((k + 1) % NS));
      step();
    end

    // Backpressure: all sources push every cycle; tag = {src, per-source seq}
    for (int i = 0; i < NS; i++) begin
      acc[i] = 0;
      bc[i]  = 0;
    end
    seen_low = 1'b0;
    for (int cyc = 0; cyc < 56; cyc++) begin
      if (cdb_valid) begin
        s       = cdb_src;
        seq     = 4'(bc[s]);
        exp_tag = {s, seq};
        check_eq("bp_tag",   64'(cdb_tag),   64'(exp_tag));
        check_eq("bp_value", 64'(cdb_value), 64'(32'hB000_0000 | DW'(exp_tag)));
        bc[s]++;
      end
      clear_src();
      if (cyc < 40) begin
        for (int i = 0; i < NS; i++) begin
          seq = 4'(acc[i]);
          set_src(i, {2'(i), seq}, 32'hB000_0000 | DW'({2'(i), seq}));
          if (src_ready[i]) acc[i]++;
        end
        if (!src_ready[0]) seen_low = 1'b1;
      end
      step();
    end
    clear_src();
    check_eq("bp_ready0_dropped", 64'(seen_low), 64'h1);
    for (int i = 0; i < NS; i++) begin
      check_eq("bp_count", 64'(bc[i]), 64'(acc[i]));
    end
    check_eq("bp_ready_idle", 64'(src_ready), 64'hF);

    // Reset mid-operation
    for (int i = 0; i < NS; i++) set_src(i, TB'(50 + i), 32'h5000_0000 + DW'(i));
    step();
    clear_src();
    step();
    check_eq("mid_busy", 64'(cdb_valid), 64'h1);
    reset = 1'b1;
    #1;
    check_eq("mid_ready_in_rst", 64'(src_ready), 64'h0);
    step();
    check_eq("mid_valid", 64'(cdb_valid), 64'h0);
    check_eq("mid_tag",   64'(cdb_tag),   64'h0);
    check_eq("mid_value", 64'(cdb_value), 64'h0);
    check_eq("mid_src",   64'(cdb_src),   64'h0);
    check_eq("mid_ready", 64'(src_ready), 64'h0);
    reset = 1'b0;
    #1;
    check_eq("mid_rel_ready", 64'(src_ready), 64'hF);
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("mid_no_stale", 64'(cdb_valid), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
